// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a valid/ready byte handshake.
// Bit time is DIV = FREQ/RATE clock cycles. o_tx is registered and idles high.
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit between
// the last data bit and the stop bit (frame grows from 10 to 11 bit times).
module uart_tx #(
    parameter int FREQ = 50_000_000,
    parameter int RATE = 2_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_data,
    input  logic       i_vld,
    output logic       o_rdy,
    output logic       o_tx,
    output logic       o_busy
);

    localparam int DIV = FREQ / RATE;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

    // A bit shorter than two clocks cannot be timed by this counter scheme.
    if (DIV < 2) begin : g_div_check
        $error("uart_tx: FREQ/RATE must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          bit_end;
`ifdef UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    assign bit_end = (baud_q == BAUD_LAST);

    // State register: synchronous reset abandons any frame and wins over accept.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (rst) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // Next-state logic: accept in IDLE, then advance one bit every DIV cycles.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        state_d   = state_q;
        baud_d    = bit_end ? '0 : baud_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (i_vld) begin
                    state_d   = S_START;
                    shift_d   = i_data;
                    bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^i_data;
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (bit_end) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: line level is decoded from the upcoming state so o_tx can be
    // registered without adding a cycle of latency; handshake flags from state_q.
    always_comb begin
        o_rdy  = (state_q == S_IDLE);
        o_busy = (state_q != S_IDLE);
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    assign o_tx = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx with FREQ=8, RATE=1 (DIV=8).
// Every line cycle of each frame is compared against a bit list built from the byte.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int DIV = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] i_data;
    logic       i_vld;
    logic       o_rdy;
    logic       o_tx;
    logic       o_busy;

    int n_pass  = 0;
    int n_total = 0;

    uart_tx #(.FREQ(8), .RATE(1)) dut (
        .clk   (clk),
        .rst   (rst),
        .i_data(i_data),
        .i_vld (i_vld),
        .o_rdy (o_rdy),
        .o_tx  (o_tx),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the first cycle after the accept edge. Walks the whole frame,
    // optionally pulsing i_vld for one cycle at index pulse_at (must be ignored).
    // Returns in the first cycle after the stop bit.
    task automatic check_frame(input logic [7:0] b, input int pulse_at, input string tag);
        logic exp_bits [0:10];
        int   cyc;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
        exp_bits[9]  = ^b;
        exp_bits[10] = 1'b1;
`else
        exp_bits[9]  = 1'b1;
        exp_bits[10] = 1'b1;
`endif
        cyc = 0;
        for (int i = 0; i < NBITS; i++) begin
            for (int c = 0; c < DIV; c++) begin
                check($sformatf("%s_tx_b%0d_c%0d", tag, i, c), o_tx, exp_bits[i]);
                check($sformatf("%s_busy_b%0d", tag, i), o_busy, 1);
                check($sformatf("%s_rdy_b%0d", tag, i), o_rdy, 0);
                if (cyc == pulse_at) begin
                    i_vld  = 1'b1;
                    i_data = 8'h42;
                end
                tick();
                if (cyc == pulse_at) i_vld = 1'b0;
                cyc++;
            end
        end
        check({tag, "_end_rdy"}, o_rdy, 1);
        check({tag, "_end_busy"}, o_busy, 0);
        check({tag, "_end_tx"}, o_tx, 1);
    endtask

    // Present a byte in an IDLE cycle, accept it on the next edge, then scramble
    // i_data so a late change would show up as a corrupted frame.
    task automatic send(input logic [7:0] b, input string tag);
        check({tag, "_pre_rdy"}, o_rdy, 1);
        i_vld  = 1'b1;
        i_data = b;
        tick();
        i_vld  = 1'b0;
        i_data = ~b;
    endtask

    task automatic expect_idle(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            check({tag, "_idle_tx"}, o_tx, 1);
            check({tag, "_idle_busy"}, o_busy, 0);
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. Reset held with i_vld high: nothing starts.
        rst    = 1'b1;
        i_vld  = 1'b1;
        i_data = 8'hA5;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_tx", o_tx, 1);
            check("rst_busy", o_busy, 0);
        end
        rst   = 1'b0;
        i_vld = 1'b0;
        tick();
        check("post_rst_rdy", o_rdy, 1);
        expect_idle(3, "post_rst");

        // 2. Single byte 0xA5.
        send(8'hA5, "a5");
        check_frame(8'hA5, -1, "a5");

        // 3. Back-to-back 0x00 then 0xFF with i_vld held; i_data changes mid-frame.
        i_vld  = 1'b1;
        i_data = 8'h00;
        tick();
        i_data = 8'hFF;
        check_frame(8'h00, -1, "b2b0");
        tick();                 // second accept exactly 81 cycles after the first
        i_vld = 1'b0;
        check_frame(8'hFF, -1, "b2b1");

        // 4. Reset during bit 3 of 0x3C, then a clean 0x55.
        send(8'h3C, "mid");
        for (int k = 0; k < DIV * 4 + 3; k++) tick();
        check("mid_bit3_tx", o_tx, 1);
        check("mid_bit3_busy", o_busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_tx", o_tx, 1);
        check("mid_rst_rdy", o_rdy, 1);
        expect_idle(DIV * 2, "mid_rst");
        send(8'h55, "55");
        check_frame(8'h55, -1, "55");

        // 5. One-cycle i_vld pulse while busy must not queue a frame.
        send(8'h81, "ign");
        check_frame(8'h81, 20, "ign");
        expect_idle(DIV * 2, "ign");

        // 6. Parity cases (plain 8N1 frames when the parity build is off).
        send(8'hA5, "par_a5");
        check_frame(8'hA5, -1, "par_a5");
        send(8'h07, "par_07");
        check_frame(8'h07, -1, "par_07");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter: serialises bytes onto the TXD line as 8N1 frames (8 data bits, no parity, 1 stop bit).
- Companion to the existing uart_rx. Sits between a byte producer (echo path from uart_rx o_data/o_vld, or a test pattern source) and the board TXD pin in fpga_top.
- Byte acceptance uses a valid/ready handshake. Bit timing comes from an integer clock divider.

Parameters:
- FREQ, 50_000_000: input clock frequency in Hz.
- RATE, 2_000_000: baud rate in bits/s.
- DIV, FREQ/RATE (derived localparam, integer truncation): clock cycles per bit. Must be >= 2, checked at elaboration.

Ports:
- clk  input  1: system clock; all logic on posedge.
- rst  input  1: synchronous active-high reset.
- i_data  input  8: byte to send; sampled only on the accept cycle.
- i_vld  input  1: producer holds a byte on i_data.
- o_rdy  output  1: transmitter can accept a byte this cycle.
- o_tx  output  1: serial line, idle high; registered output.
- o_busy  output  1: a frame is in progress (any state other than IDLE).

Interface (already decided):
- One clock, clk.
- Reset rst is synchronous and active-high.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, o_tx=1, o_busy=0, baud counter=0, bit index=0, shift register=0.
  - o_rdy=1 from the first cycle after reset.
- Handshake:
  - A byte is accepted when i_vld && o_rdy at a clk edge.
  - o_rdy = (state==IDLE). It is combinational from state and does not depend on i_vld.
  - i_data is latched into the shift register on accept. Later changes to i_data have no effect on the frame.
  - i_vld while o_rdy=0 is ignored; nothing is queued. The producer must hold i_vld.
- States:
  - IDLE: o_tx=1. On accept, go to START with baud counter=0.
  - START: o_tx=0 for DIV cycles, then go to DATA with bit index=0.
  - DATA: o_tx=shift[0] (LSB first) for DIV cycles per bit. After each bit, shift right and increment bit index. After bit 7, go to STOP.
  - STOP: o_tx=1 for DIV cycles, then go to IDLE.
- Baud counter:
  - Counts 0..DIV-1 and wraps to 0 on each bit boundary.
  - Is held at 0 in IDLE.
- Latency:
  - Accept at edge N puts o_tx=0 from cycle N+1.
  - Frame is exactly 10*DIV cycles of line time (11*DIV with the optional feature).
  - o_rdy is back at 1 in the cycle after the stop bit ends.
- Back-to-back: if i_vld is held high, the next byte is accepted in that first IDLE cycle. Frame-to-frame pitch is therefore 10*DIV+1 cycles.
- Reset mid-frame: the frame is abandoned and o_tx=1 from the next cycle. No partial stop bit is emitted.
- Simultaneous rst and i_vld: rst wins and the byte is not accepted.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- When defined: a PARITY state is inserted between DATA and STOP.
  - Lasts DIV cycles.
  - o_tx = XOR of the 8 data bits (even parity).
  - Frame becomes 11*DIV cycles.
- When undefined: no PARITY state and no parity logic is generated. The frame is 8N1 as above.

Test Plan:
All scenarios use FREQ=8, RATE=1, so DIV=8.
1. Reset: assert rst for 3 cycles with i_vld=1 -> o_tx=1, o_busy=0, no frame starts. o_rdy=1 in the first cycle after rst drops.
2. Single byte 0xA5:
   - Accept at cycle N -> o_tx=0 for cycles N+1..N+8.
   - Data bits 1,0,1,0,0,1,0,1, 8 cycles each.
   - Stop=1 for cycles N+73..N+80.
   - o_rdy=1 at N+81.
3. Back-to-back 0x00 then 0xFF with i_vld held -> second start bit begins exactly 81 cycles after the first. i_data changed mid-frame does not corrupt byte 1.
4. Reset mid-frame: assert rst during bit 3 of 0x3C -> o_tx=1 the next cycle and state=IDLE. A fresh 0x55 afterwards transmits correctly.
5. Ignored valid: pulse i_vld for 1 cycle while o_busy=1 -> no extra frame is sent after the current one.
6. With UART_TX_PARITY_EN and byte 0xA5 -> parity bit 0 for 8 cycles after the data bits; frame is 88 cycles. With byte 0x07 -> parity bit 1.
